// File: rtl/mem_arbiter_if.sv
// Bundles the I/D requester ports and the memory port shared by the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_enablen;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [3:0]  m_enablen;
    logic [31:0] m_rdata;
    logic        uart_busy;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_enablen, m_rdata, uart_busy,
        output i_ack, i_rdata, d_ack, d_rdata, m_address, m_wdata, m_enablen
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_enablen, m_rdata, uart_busy,
        input  i_ack, i_rdata, d_ack, d_rdata, m_address, m_wdata, m_enablen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between the
// instruction-fetch (read-only) and load/store requesters; all outputs registered.
module mem_arbiter #(
    parameter logic [31:0] UART_ADDR = 32'h0001_0000
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state_q, state_d;
    // Records the most recent grant; doubles as the owner of the access in flight.
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  en_q, en_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        d_uart_hold;
    logic        i_elig;
    logic        d_elig;
    logic        grant_d;

    always_comb begin
        d_uart_hold = (bus.d_enablen != 4'b1111) && (bus.d_addr == UART_ADDR) && bus.uart_busy;
        i_elig      = bus.i_req;
        d_elig      = bus.d_req && !d_uart_hold;
        grant_d     = d_elig && (!i_elig || (last_grant_q == OWN_I));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        en_d         = '1;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_elig || d_elig) begin
                    state_d      = S_ACCESS;
                    last_grant_d = grant_d;
                    if (grant_d) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        en_d    = bus.d_enablen;
                    end else begin
                        addr_d  = bus.i_addr;
                        wdata_d = '0;
                        en_d    = '1;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (last_grant_q == OWN_D) begin
                    d_rdata_d = bus.m_rdata;
                    d_ack_d   = 1'b1;
                end else begin
                    i_rdata_d = bus.m_rdata;
                    i_ack_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= '1;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            en_q         <= en_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.m_address = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_enablen = en_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
